// File: rtl/spi_frame_receiver_if.sv
// Signal bundle between the SPI line/readout side and spi_frame_receiver.
// The master modport is the environment (drives SPI lines, consumes words).
interface spi_frame_receiver_if #(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                  sclk;
    logic                  cs_n;
    logic                  sdi;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  frame_err;
    logic                  overrun;
    logic [LW-1:0]         fifo_level;

    modport master (
        output sclk, cs_n, sdi, out_ready,
        input  out_data, out_valid, frame_err, overrun, fifo_level
    );

    modport slave (
        input  sclk, cs_n, sdi, out_ready,
        output out_data, out_valid, frame_err, overrun, fifo_level
    );
endinterface

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 frame receiver: synchronises sclk/cs_n/sdi into clk, assembles
// MSB-first words and buffers them in a first-word-fall-through FIFO.
module spi_frame_receiver #(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_frame_receiver_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] csn_ff;
    logic [SYNC_STAGES-1:0] sdi_ff;
    logic                   sclk_s;
    logic                   csn_s;
    logic                   sdi_s;
    logic                   sclk_d;
    logic                   rise_q;
    logic                   csn_q;
    logic                   sdi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_ff <= '0;
            csn_ff  <= '1;
            sdi_ff  <= '0;
        end else begin
            sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], bus.sclk};
            csn_ff  <= {csn_ff[SYNC_STAGES-2:0],  bus.cs_n};
            sdi_ff  <= {sdi_ff[SYNC_STAGES-2:0],  bus.sdi};
        end
    end

    assign sclk_s = sclk_ff[SYNC_STAGES-1];
    assign csn_s  = csn_ff[SYNC_STAGES-1];
    assign sdi_s  = sdi_ff[SYNC_STAGES-1];

    // Edge pulse, data and select are registered together so the FSM sees
    // a coincident cs_n rise and sclk rise in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d <= 1'b0;
            rise_q <= 1'b0;
            csn_q  <= 1'b1;
            sdi_q  <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            rise_q <= sclk_s & ~sclk_d;
            csn_q  <= csn_s;
            sdi_q  <= sdi_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                state, state_nx;
    logic [CW-1:0]         bit_cnt, bit_cnt_nx;
    logic [DATA_WIDTH-1:0] shift, shift_nx;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_word;
    logic                  err_nx;
    logic                  frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            shift       <= shift_nx;
            frame_err_q <= err_nx;
        end
    end

    assign push_word = {shift[DATA_WIDTH-2:0], sdi_q};

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        push       = 1'b0;
        err_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!csn_q) begin
                    state_nx   = RECV;
                    bit_cnt_nx = '0;
                end
            end
            RECV: begin
                // cs_n release wins over a simultaneous sclk edge
                if (csn_q) begin
                    state_nx   = IDLE;
                    err_nx     = (bit_cnt != '0);
                    bit_cnt_nx = '0;
                end else if (rise_q) begin
                    shift_nx   = push_word;
                    bit_cnt_nx = bit_cnt + 1'b1;
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        push       = 1'b1;
                        state_nx   = HOLD;
                        bit_cnt_nx = '0;
                    end
                end
            end
            HOLD: begin
                if (csn_q) state_nx = IDLE;
            end
            default: begin
                state_nx   = IDLE;
                bit_cnt_nx = '0;
            end
        endcase
    end

    assign bus.frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [LW-1:0]         wr_ptr;
    logic [LW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic                  full;
    logic                  pop;
    logic                  wr_en;
    logic                  overrun_q;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LW'(FIFO_DEPTH));
    assign pop   = (level != '0) & bus.out_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && !wr_en) overrun_q <= 1'b1;
        end
    end

    assign bus.out_valid  = (level != '0);
    assign bus.out_data   = bus.out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign bus.overrun    = overrun_q;
    assign bus.fifo_level = level;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: expected words go into a scoreboard
// queue, a negedge monitor pops and compares whenever a word is consumed.
module tb_spi_frame_receiver;
    localparam int DW = 12;
    localparam int SS = 2;
    localparam int FD = 4;

    logic clk;
    logic rst;

    spi_frame_receiver_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus();

    spi_frame_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int last_rise_cyc   = 0;
    int first_valid_cyc = 0;
    int vcnt    = 0;
    int err_cnt = 0;
    logic [DW-1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: scoreboard compare on every accepted word, plus event counters
    initial begin
        logic vprev;
        vprev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.out_valid && !vprev) first_valid_cyc = cyc;
                if (bus.out_valid) vcnt++;
                if (bus.frame_err) err_cnt++;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL unexpected_pop: got %0h expected none", bus.out_data);
                    end else begin
                        check("pop_data", {20'd0, bus.out_data}, {20'd0, exp_q.pop_front()});
                    end
                end
                vprev = bus.out_valid;
            end else begin
                vprev = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sclk_bit(input logic b);
        bus.sdi = b;
        tick(4);
        bus.sclk = 1'b1;
        tick(4);
        bus.sclk = 1'b0;
    endtask

    // nclk sclk pulses; first DW carry w MSB-first. pop_last raises out_ready
    // for exactly the cycle in which the completed word is pushed.
    task automatic send_frame(input logic [DW-1:0] w, input int nclk, input bit pop_last);
        bus.cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < nclk; i++) begin
            bus.sdi = (i < DW) ? w[DW-1-i] : 1'b0;
            tick(4);
            bus.sclk = 1'b1;
            if (i == DW - 1) last_rise_cyc = cyc;
            if (i == DW - 1 && pop_last) begin
                tick(SS + 1);
                bus.out_ready = 1'b1;
                tick(1);
                bus.out_ready = 1'b0;
            end else begin
                tick(4);
            end
            bus.sclk = 1'b0;
        end
        tick(4);
        bus.cs_n = 1'b1;
        tick(8);
    endtask

    initial begin
        int e0;
        int v0;
        rst = 1'b1;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.sdi = 1'b0;
        bus.out_ready = 1'b0;
        tick(3);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_fifo_level", bus.fifo_level, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_frame_err", bus.frame_err, 0);
        rst = 1'b0;
        tick(4);

        // Single frame, latency and single-cycle valid
        bus.out_ready = 1'b1;
        e0 = err_cnt; v0 = vcnt;
        exp_q.push_back(12'hA5C);
        send_frame(12'hA5C, DW, 1'b0);
        check("latency", first_valid_cyc - last_rise_cyc, SS + 2);
        check("valid_pulse_cycles", vcnt - v0, 1);
        check("t1_frame_err", err_cnt - e0, 0);
        check("t1_overrun", bus.overrun, 0);

        // Short frame -> one frame_err pulse, nothing stored
        e0 = err_cnt;
        send_frame(12'h000, 7, 1'b0);
        check("short_err_pulse", err_cnt - e0, 1);
        check("short_level", bus.fifo_level, 0);
        exp_q.push_back(12'h3C3);
        send_frame(12'h3C3, DW, 1'b0);

        // 14 pulses -> exactly one word
        e0 = err_cnt;
        exp_q.push_back(12'h9E1);
        send_frame(12'h9E1, 14, 1'b0);
        check("long_frame_err", err_cnt - e0, 0);
        check("long_sb_empty", exp_q.size(), 0);

        // Overrun: five frames with consumer stalled
        bus.out_ready = 1'b0;
        exp_q.push_back(12'h001); send_frame(12'h001, DW, 1'b0);
        exp_q.push_back(12'h800); send_frame(12'h800, DW, 1'b0);
        exp_q.push_back(12'hFFF); send_frame(12'hFFF, DW, 1'b0);
        exp_q.push_back(12'h555); send_frame(12'h555, DW, 1'b0);
        check("ovr_level_full", bus.fifo_level, 4);
        check("ovr_before", bus.overrun, 0);
        send_frame(12'hAAA, DW, 1'b0);
        check("ovr_set", bus.overrun, 1);
        check("ovr_level_kept", bus.fifo_level, 4);
        bus.out_ready = 1'b1;
        tick(10);
        check("ovr_drained", bus.fifo_level, 0);
        check("ovr_sticky", bus.overrun, 1);
        check("ovr_sb_empty", exp_q.size(), 0);

        // Reset mid-frame with a word already buffered
        bus.out_ready = 1'b0;
        send_frame(12'h0F0, DW, 1'b0);
        check("pre_rst_level", bus.fifo_level, 1);
        e0 = err_cnt;
        bus.cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < 6; i++) sclk_bit(1'b1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_data", bus.out_data, 0);
        check("mid_rst_level", bus.fifo_level, 0);
        check("mid_rst_overrun", bus.overrun, 0);
        check("mid_rst_err", bus.frame_err, 0);
        bus.cs_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        bus.out_ready = 1'b1;
        exp_q.push_back(12'h123);
        send_frame(12'h123, DW, 1'b0);
        check("post_rst_err", err_cnt - e0, 0);

        // Full FIFO with push and pop in the same cycle
        bus.out_ready = 1'b0;
        exp_q.push_back(12'h111); send_frame(12'h111, DW, 1'b0);
        exp_q.push_back(12'h222); send_frame(12'h222, DW, 1'b0);
        exp_q.push_back(12'h333); send_frame(12'h333, DW, 1'b0);
        exp_q.push_back(12'h444); send_frame(12'h444, DW, 1'b0);
        check("sim_level_full", bus.fifo_level, 4);
        exp_q.push_back(12'h5A5);
        send_frame(12'h5A5, DW, 1'b1);
        check("sim_level_kept", bus.fifo_level, 4);
        check("sim_overrun", bus.overrun, 0);
        bus.out_ready = 1'b1;
        tick(10);
        check("sim_drained", bus.fifo_level, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
